// File: rtl/ks_ctrl_pkg.sv
// Shared definitions for the slice-serial arbitrated adder controller.
package ks_ctrl_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ks_slice4.sv
// Combinational 4-bit Kogge-Stone adder slice with carry-in.
module ks_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] p0;
  logic [3:0] g0;
  logic [3:0] g1;
  logic       p1_2;
  logic       p1_3;
  logic [3:0] g2;

  // Bit-level propagate/generate; carry-in is folded into the bit-0 generate.
  assign p0 = a ^ b;
  assign g0 = {a[3:1] & b[3:1], (a[0] & b[0]) | (p0[0] & cin)};

  // Prefix level 1 (span 1).
  assign g1   = {g0[3] | (p0[3] & g0[2]),
                 g0[2] | (p0[2] & g0[1]),
                 g0[1] | (p0[1] & g0[0]),
                 g0[0]};
  assign p1_2 = p0[2] & p0[1];
  assign p1_3 = p0[3] & p0[2];

  // Prefix level 2 (span 2); g2[i] is the carry out of bit i.
  assign g2 = {g1[3] | (p1_3 & g1[1]),
               g1[2] | (p1_2 & g1[0]),
               g1[1],
               g1[0]};

  assign s    = p0 ^ {g2[2:0], cin};
  assign cout = g2[3];

endmodule

// File: rtl/ks_seq_add_arb.sv
// Round-robin arbitrated wide adder that sequences a shared 4-bit slice LSB first.
module ks_seq_add_arb
  import ks_ctrl_pkg::*;
#(
  parameter int unsigned NSLICE = 4,
  parameter int unsigned NREQ   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NREQ-1:0]                    req_valid,
  output logic [NREQ-1:0]                    req_ready,
  input  logic [NREQ*NSLICE*SLICE_W-1:0]     req_a,
  input  logic [NREQ*NSLICE*SLICE_W-1:0]     req_b,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [idx_width(NREQ)-1:0]         rsp_id,
  output logic [NSLICE*SLICE_W-1:0]          rsp_sum,
  output logic                               rsp_cout
);

  localparam int unsigned W   = SLICE_W * NSLICE;
  localparam int unsigned IDW = idx_width(NREQ);
  localparam int unsigned SW  = idx_width(NSLICE);

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            carry_q;
  logic            cout_q;
  logic            rsp_valid_q;
  logic [SW-1:0]   idx_q;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  ptr_d;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic            sl_c;
  logic            last_slice;

  // Round-robin search: first pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned c = 0; c < NREQ; c++) begin
        if (!gnt_found && req_valid[c] && ((pass == 0) == (c >= 32'(ptr_q)))) begin
          gnt_found = 1'b1;
          gnt_idx   = IDW'(c);
        end
      end
    end
  end

  // Pointer moves to the requester just after the winner.
  assign ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);

  // Only the winner sees ready, and only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    for (int unsigned c = 0; c < NREQ; c++) begin
      req_ready[c] = (state_q == IDLE) && !rst && gnt_found && (gnt_idx == IDW'(c));
    end
  end

  // Operand select for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned c = 0; c < NREQ; c++) begin
      if (gnt_idx == IDW'(c)) begin
        sel_a = req_a[c*W +: W];
        sel_b = req_b[c*W +: W];
      end
    end
  end

  // Present the current slice of the latched operands to the shared adder.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned s = 0; s < NSLICE; s++) begin
      if (idx_q == SW'(s)) begin
        sl_a = a_q[s*SLICE_W +: SLICE_W];
        sl_b = b_q[s*SLICE_W +: SLICE_W];
      end
    end
  end

  assign last_slice = (32'(idx_q) == NSLICE - 1);

  ks_slice4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_c)
  );

  // Controller FSM with operand, sum, carry and slice-index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            id_q    <= gnt_idx;
            carry_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= ptr_d;
            state_q <= CALC;
          end
        end
        CALC: begin
          for (int unsigned s = 0; s < NSLICE; s++) begin
            if (idx_q == SW'(s)) begin
              sum_q[s*SLICE_W +: SLICE_W] <= sl_s;
            end
          end
          carry_q <= sl_c;
          idx_q   <= idx_q + SW'(1);
          if (last_slice) begin
            cout_q      <= sl_c;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;

endmodule
